// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage redirect/stall sequencer for programCounter.
// Arbitrates trap, branch and jump redirects; holds and drains.
module pc_redirect_ctrl #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0040,
  parameter int unsigned TRAP_DRAIN  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_curr,
  input  logic        imem_busy,
  input  logic        hazard_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_req,
  input  logic [31:0] jmp_target,
  input  logic        trap_req,
  output logic        stall,
  output logic        jump_cs,
  output logic [31:0] next_pc,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        redirect_pending,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(TRAP_DRAIN - 1);

  state_t      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] epc_q, epc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        has_req;
  logic [31:0] req_tgt;

  // Winner among branch and jump; the branch wins.
  assign has_req = br_taken | jmp_req;
  assign req_tgt = br_taken ? br_target : jmp_target;
  assign epc     = epc_q;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pend_q  <= '0;
      epc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d          = state_q;
    pend_d           = pend_q;
    epc_d            = epc_q;
    cnt_d            = cnt_q;
    stall            = 1'b0;
    jump_cs          = 1'b0;
    next_pc          = '0;
    flush_ifid       = 1'b0;
    flush_idex       = 1'b0;
    redirect_pending = 1'b0;
    if (!rst_n) begin
      stall      = 1'b1;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else begin
      unique case (state_q)
        DRAIN: begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (cnt_q != '0) begin
            stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
          end else if (!imem_busy) begin
            jump_cs = 1'b1;
            next_pc = TRAP_VECTOR;
            state_d = RUN;
          end else begin
            stall   = 1'b1;
            pend_d  = TRAP_VECTOR;
            state_d = HOLD;
          end
        end
        HOLD: begin
          redirect_pending = 1'b1;
          if (trap_req) begin
            stall      = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            epc_d      = pc_curr;
            cnt_d      = DRAIN_INIT;
            pend_d     = '0;
            state_d    = DRAIN;
          end else begin
            flush_ifid = has_req;
            flush_idex = br_taken;
            if (has_req) pend_d = req_tgt;
            if (imem_busy) begin
              stall = 1'b1;
            end else begin
              jump_cs = 1'b1;
              next_pc = has_req ? req_tgt : pend_q;
              state_d = RUN;
            end
          end
        end
        default: begin
          if (trap_req) begin
            stall      = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            epc_d      = pc_curr;
            cnt_d      = DRAIN_INIT;
            state_d    = DRAIN;
          end else if (has_req) begin
            flush_ifid = 1'b1;
            flush_idex = br_taken;
            if (imem_busy) begin
              stall   = 1'b1;
              pend_d  = req_tgt;
              state_d = HOLD;
            end else begin
              jump_cs = 1'b1;
              next_pc = req_tgt;
            end
          end else if (imem_busy || hazard_stall) begin
            stall      = 1'b1;
            flush_idex = hazard_stall;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Randomized bench for pc_redirect_ctrl against a reference model.
// Also models the programCounter that consumes the outputs.
module tb_pc_redirect_ctrl;

  localparam logic [31:0] TV = 32'h0000_0040;
  localparam int          TD = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_curr;
  logic        imem_busy, hazard_stall;
  logic        br_taken, jmp_req, trap_req;
  logic [31:0] br_target, jmp_target;
  logic        stall, jump_cs, flush_ifid, flush_idex;
  logic        redirect_pending;
  logic [31:0] next_pc, epc;

  int errs = 0;
  int checks = 0;

  // Reference model: drain countdown (-1 = not draining),
  // a held redirect flag/target, captured epc and the PC.
  int          m_drain = -1;
  bit          m_hold = 1'b0;
  logic [31:0] m_tgt = '0;
  logic [31:0] m_epc = '0;
  logic [31:0] m_pc = '0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(
    .TRAP_VECTOR(TV),
    .TRAP_DRAIN (TD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_curr         (pc_curr),
    .imem_busy       (imem_busy),
    .hazard_stall    (hazard_stall),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .jmp_req         (jmp_req),
    .jmp_target      (jmp_target),
    .trap_req        (trap_req),
    .stall           (stall),
    .jump_cs         (jump_cs),
    .next_pc         (next_pc),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .redirect_pending(redirect_pending),
    .epc             (epc)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against model, advance.
  task automatic step(input bit rs, input bit bsy,
                      input bit hz, input bit b,
                      input logic [31:0] bt, input bit j,
                      input logic [31:0] jt, input bit t);
    bit          e_st, e_j, e_fi, e_fe, e_pd, has;
    logic [31:0] e_np, tgt;
    @(negedge clk);
    rst_n        = rs;
    imem_busy    = bsy;
    hazard_stall = hz;
    br_taken     = b;
    br_target    = bt;
    jmp_req      = j;
    jmp_target   = jt;
    trap_req     = t;
    pc_curr      = m_pc;
    #1;
    e_st = 0; e_j = 0; e_fi = 0; e_fe = 0; e_pd = 0;
    e_np = '0;
    has  = b | j;
    tgt  = b ? bt : jt;
    if (!rs) begin
      e_st = 1; e_fi = 1; e_fe = 1;
    end else if (m_drain >= 0) begin
      e_fi = 1; e_fe = 1;
      if (m_drain == 0 && !bsy) begin
        e_j = 1; e_np = TV;
      end else begin
        e_st = 1;
      end
    end else if (t) begin
      e_pd = m_hold;
      e_st = 1; e_fi = 1; e_fe = 1;
    end else begin
      e_pd = m_hold;
      e_fi = has;
      e_fe = b;
      if (m_hold || has) begin
        if (bsy) e_st = 1;
        else begin
          e_j  = 1;
          e_np = has ? tgt : m_tgt;
        end
      end else if (bsy || hz) begin
        e_st = 1;
        e_fe = hz;
      end
    end
    check("stall", 32'(stall), 32'(e_st));
    check("jump_cs", 32'(jump_cs), 32'(e_j));
    check("next_pc", next_pc, e_np);
    check("flush_ifid", 32'(flush_ifid), 32'(e_fi));
    check("flush_idex", 32'(flush_idex), 32'(e_fe));
    check("pending", 32'(redirect_pending), 32'(e_pd));
    check("epc", epc, m_epc);
    check("excl", 32'(stall & jump_cs), 32'd0);
    @(posedge clk);
    if (!rs) begin
      m_drain = -1; m_hold = 0; m_tgt = '0; m_epc = '0;
      m_pc = '0;
    end else begin
      if (m_drain > 0) begin
        m_drain--;
      end else if (m_drain == 0) begin
        m_drain = -1;
        if (bsy) begin
          m_hold = 1; m_tgt = TV;
        end
      end else if (t) begin
        m_epc = m_pc; m_drain = TD - 1; m_hold = 0;
        m_tgt = '0;
      end else if (m_hold) begin
        if (has) m_tgt = tgt;
        if (!bsy) m_hold = 0;
      end else if (has && bsy) begin
        m_hold = 1; m_tgt = tgt;
      end
      if (e_j) m_pc = e_np;
      else if (!e_st) m_pc = m_pc + 32'd1;
    end
  endtask

  task automatic idle(input bit bsy);
    step(1, bsy, 0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    rst_n = 0; imem_busy = 0; hazard_stall = 0;
    br_taken = 0; jmp_req = 0; trap_req = 0;
    br_target = '0; jmp_target = '0; pc_curr = '0;
    repeat (2) step(0, 0, 0, 0, '0, 0, '0, 0);
    repeat (4) idle(0);
    check("pc_count", m_pc, 32'd4);
    step(1, 0, 0, 1, 32'h20, 0, '0, 0);
    check("pc_branch", m_pc, 32'h20);
    step(1, 0, 0, 1, 32'h50, 1, 32'h30, 0);
    step(1, 1, 0, 0, '0, 1, 32'h44, 0);
    idle(1); idle(1);
    idle(0);
    check("pc_hold", m_pc, 32'h44);
    step(1, 0, 0, 0, '0, 1, 32'h12, 0);
    step(1, 0, 0, 0, '0, 0, '0, 1);
    step(1, 0, 0, 1, 32'h99, 0, '0, 0);
    idle(0); idle(0);
    check("pc_trap", m_pc, TV);
    check("epc_trap", epc, 32'h12);
    step(1, 0, 1, 0, '0, 0, '0, 0);
    step(1, 1, 0, 0, '0, 1, 32'h70, 0);
    idle(1);
    step(0, 1, 0, 0, '0, 0, '0, 0);
    idle(0); idle(0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(63) != 0,
           $urandom_range(2) == 0,
           $urandom_range(3) == 0,
           $urandom_range(5) == 0, $urandom(),
           $urandom_range(4) == 0, $urandom(),
           $urandom_range(19) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
